// File: rtl/axis_burst_source_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_burst_source_if
// Brief    : AXI4-Stream master/slave bundle used by axis_burst_source.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_burst_source_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (
    output tdata,
    output tstrb,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/axis_burst_source.sv
`default_nettype none
// ============================================================================
// Module   : axis_burst_source
// Brief    : Emits one AXI4-Stream burst of burst_len beats per start request;
//            data increments from seed, or follows a 32-bit Galois LFSR when
//            AXIS_SRC_LFSR_EN is defined (DATA_WIDTH must then be 32).
// Revision : 1.0 - initial release
// ============================================================================
module axis_burst_source #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                 m01_axis_aclk,
  input  logic                 m01_axis_areset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                 busy,
  output logic                 done,
  axis_burst_source_if.master  m01_axis
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q,  state_d;
  logic [LEN_WIDTH-1:0]    cnt_q,    cnt_d;
  logic [LEN_WIDTH-1:0]    len_q,    len_d;
  logic [DATA_WIDTH-1:0]   tdata_q,  tdata_d;
  logic [DATA_WIDTH/8-1:0] tstrb_q,  tstrb_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q,  tlast_d;
  logic                    done_q,   done_d;
  logic                    busy_q,   busy_d;

  logic [DATA_WIDTH-1:0]   seed_eff;
  logic [DATA_WIDTH-1:0]   data_next;

`ifdef AXIS_SRC_LFSR_EN
  // Taps for x^32+x^22+x^2+x+1 in right-shifting Galois form; zero would lock up.
  localparam logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(32'h8020_0003);

  assign seed_eff  = (seed == '0) ? DATA_WIDTH'(1) : seed;
  assign data_next = {1'b0, tdata_q[DATA_WIDTH-1:1]} ^ (tdata_q[0] ? LFSR_TAPS : '0);
`else
  assign seed_eff  = seed;
  assign data_next = tdata_q + DATA_WIDTH'(1);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    tdata_d  = tdata_q;
    tstrb_d  = tstrb_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    done_d   = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start && (burst_len != '0)) begin
          state_d  = S_SEND;
          len_d    = burst_len;
          cnt_d    = '0;
          tdata_d  = seed_eff;
          tstrb_d  = '1;
          tvalid_d = 1'b1;
          tlast_d  = (burst_len == LEN_WIDTH'(1));
          busy_d   = 1'b1;
        end
      end

      S_SEND: begin
        if (tvalid_q && m01_axis.tready) begin
          if (tlast_q) begin
            state_d  = S_DONE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tstrb_d  = '0;
            tdata_d  = '0;
            done_d   = 1'b1;
          end else begin
            // cnt never passes len-1, so it cannot wrap for any legal length.
            cnt_d   = cnt_q + LEN_WIDTH'(1);
            tdata_d = data_next;
            tlast_d = (cnt_d == (len_q - LEN_WIDTH'(1)));
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tstrb_d  = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge m01_axis_aclk or posedge m01_axis_areset) begin
    if (m01_axis_areset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      tdata_q  <= tdata_d;
      tstrb_q  <= tstrb_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign m01_axis.tdata  = tdata_q;
  assign m01_axis.tstrb  = tstrb_q;
  assign m01_axis.tvalid = tvalid_q;
  assign m01_axis.tlast  = tlast_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
`default_nettype wire
